// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  // Bubble instruction: addi x0,x0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Issue FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    REQ  = 2'd1,  // request on the bus, address held until the transfer
    DROP = 2'd2   // outstanding request made stale by a redirect
  } fetch_state_t;

  // IF/ID entry, also the fetch buffer payload
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Fetch unit side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, inst} between instruction memory and IF/ID.
// Flush empties the FIFO; a push in the same cycle lands in the emptied FIFO.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  if_id_t     push_data,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output if_id_t     head
);

  if_id_t mem [2];
  logic   rd_ptr;
  logic   wr_ptr;
  logic   full;
  logic   do_pop;

  assign full   = (count == 2'd2);
  assign do_pop = pop && (count != 2'd0);
  assign head   = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= push;
      count  <= {1'b0, push};
    end else begin
      if (push)   wr_ptr <= ~wr_ptr;
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count alone decides which entries are meaningful.
    if (push) mem[flush ? 1'b0 : wr_ptr] <= push_data;
  end

  // The issue gate never lets a push meet a full FIFO
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !do_pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches from pc_q, buffers returned
// instructions in a 2-entry FIFO and feeds the IF/ID register, with a
// same-edge bypass when the FIFO is empty.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = fetch_unit_pkg::NOP_INST
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                PC_EN_IF,
  input  logic                reg_FD_EN,
  input  logic                reg_FD_stall,
  input  logic                reg_FD_flush,
  input  logic                Branch_ID,
  input  logic [31:0]         branch_target_ID,
  fetch_unit_if.master        imem,
  output logic [31:0]         inst_FD,
  output logic [31:0]         PC_FD,
  output logic                valid_FD,
  output logic                fetch_starved
);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  addr_q;
  logic [31:0]  pc_next;
  logic [1:0]   buf_count;
  logic [1:0]   count_next;
  if_id_t       buf_head;
  if_id_t       push_data;
  logic         xfer;
  logic         good_data;
  logic         load_slot;
  logic         pop;
  logic         bypass;
  logic         push;
  logic         issue_next;

  // Request generation: IDLE issues from pc_q when there is room, otherwise
  // the held address of the outstanding request is driven.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    imem.imem_req  = 1'b1;
    imem.imem_addr = addr_q;
    if (state == IDLE) begin
      imem.imem_req  = PC_EN_IF && (buf_count < 2'd2);
      imem.imem_addr = pc_q;
    end
    if (!rst_n) imem.imem_req = 1'b0;
  end

  // Data returned under a redirect or for a stale request is discarded
  assign xfer      = imem.imem_req && imem.imem_ack;
  assign good_data = xfer && (state != DROP) && !Branch_ID;
  assign load_slot = !reg_FD_flush && reg_FD_EN && !reg_FD_stall;
  assign pop       = load_slot && (buf_count != 2'd0);
  assign bypass    = load_slot && (buf_count == 2'd0) && good_data;
  assign push      = good_data && !bypass;
  assign push_data = '{pc: imem.imem_addr, inst: imem.imem_rdata};

  assign fetch_starved = rst_n && reg_FD_EN && !reg_FD_stall &&
                         (buf_count == 2'd0) && !good_data;

  // Next PC and post-edge occupancy used for back-to-back issue
  always_comb begin
    pc_next    = pc_q;
    count_next = buf_count;
    if (Branch_ID)                      pc_next = branch_target_ID;
    else if (xfer && (state != DROP))   pc_next = pc_q + 32'd4;
    if (reg_FD_flush) begin
      count_next = {1'b0, push};
    end else begin
      case ({push, pop})
        2'b10:   count_next = buf_count + 2'd1;
        2'b01:   count_next = buf_count - 2'd1;
        default: count_next = buf_count;
      endcase
    end
    issue_next = PC_EN_IF && (count_next < 2'd2);
  end

  // Issue FSM and fetch PC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
      case (state)
        IDLE: begin
          if (imem.imem_req) begin
            if (xfer) begin
              if (issue_next) begin
                state  <= REQ;
                addr_q <= pc_next;
              end
            end else begin
              state  <= Branch_ID ? DROP : REQ;
              addr_q <= pc_q;
            end
          end
        end
        REQ: begin
          if (xfer) begin
            if (issue_next) addr_q <= pc_next;
            else            state  <= IDLE;
          end else if (Branch_ID) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (xfer) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // IF/ID register: flush > hold > head/bypass > bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_FD  <= NOP_INST;
      PC_FD    <= 32'd0;
      valid_FD <= 1'b0;
    end else if (reg_FD_flush) begin
      inst_FD  <= NOP_INST;
      valid_FD <= 1'b0;
    end else if (load_slot) begin
      if (pop) begin
        PC_FD    <= buf_head.pc;
        inst_FD  <= buf_head.inst;
        valid_FD <= 1'b1;
      end else if (bypass) begin
        PC_FD    <= imem.imem_addr;
        inst_FD  <= imem.imem_rdata;
        valid_FD <= 1'b1;
      end else begin
        inst_FD  <= NOP_INST;
        valid_FD <= 1'b0;
      end
    end
  end

  fetch_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (reg_FD_flush),
    .count     (buf_count),
    .head      (buf_head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a per-cycle vector table for start-up
// and wait states, hand sequences for stall, redirect, flush and reset, and
// a scoreboard of accepted fetches compared at every IF/ID load.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PC_EN_IF = 1'b0;
  logic        reg_FD_EN = 1'b0;
  logic        reg_FD_stall = 1'b0;
  logic        reg_FD_flush = 1'b0;
  logic        Branch_ID = 1'b0;
  logic [31:0] branch_target_ID = 32'd0;
  logic [31:0] inst_FD;
  logic [31:0] PC_FD;
  logic        valid_FD;
  logic        fetch_starved;

  fetch_unit_if imem ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .PC_EN_IF         (PC_EN_IF),
    .reg_FD_EN        (reg_FD_EN),
    .reg_FD_stall     (reg_FD_stall),
    .reg_FD_flush     (reg_FD_flush),
    .Branch_ID        (Branch_ID),
    .branch_target_ID (branch_target_ID),
    .imem             (imem),
    .inst_FD          (inst_FD),
    .PC_FD            (PC_FD),
    .valid_FD         (valid_FD),
    .fetch_starved    (fetch_starved)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_starved;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t   vecs [10];
  if_id_t sb [$];
  int     checks = 0;
  int     errors = 0;
  bit     drop_pending = 1'b0;
  bit     load_prev = 1'b0;
  int     n;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive the memory response for this cycle and record what must reach IF/ID
  task automatic pre(input logic ack);
    logic kept;
    imem.imem_ack = ack;
    #1;
    imem.imem_rdata = inst_of(imem.imem_addr);
    kept = imem.imem_req && ack && !Branch_ID && !drop_pending;
    if (!rst_n) begin
      sb.delete();
      drop_pending = 1'b0;
    end else begin
      if (reg_FD_flush) sb.delete();
      if (kept) sb.push_back('{pc: imem.imem_addr, inst: inst_of(imem.imem_addr)});
      if (imem.imem_req && ack) drop_pending = 1'b0;
      if (Branch_ID && imem.imem_req && !ack) drop_pending = 1'b1;
    end
    load_prev = rst_n && reg_FD_EN && !reg_FD_stall && !reg_FD_flush;
  endtask

  // Clock edge, then compare any IF/ID load against the scoreboard
  task automatic post();
    if_id_t e;
    @(posedge clk);
    #1;
    if (load_prev) begin
      if (sb.size() == 0) begin
        check("sb_bubble_valid", valid_FD, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_valid", valid_FD, 32'd1);
        check("sb_pc", PC_FD, e.pc);
        check("sb_inst", inst_FD, e.inst);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    //          ack   stall exp_req exp_addr     starved valid exp_pc
    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b1, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 32'h0000_0004};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b1, 32'h0000_0008};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_000C};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_000C};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_000C};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0000_000C};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 32'h0000_0014, 1'b0, 1'b1, 32'h0000_0010};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 32'h0000_0018, 1'b0, 1'b1, 32'h0000_0014};

    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'd0;

    // Reset with enables high and a stray ack: no request, no starvation
    PC_EN_IF  = 1'b1;
    reg_FD_EN = 1'b1;
    rst_n     = 1'b0;
    pre(1'b1);
    check("rst_req", imem.imem_req, 32'd0);
    check("rst_starved", fetch_starved, 32'd0);
    post();
    pre(1'b1);
    check("rst_req2", imem.imem_req, 32'd0);
    check("rst_valid", valid_FD, 32'd0);
    check("rst_inst", inst_FD, 32'h0000_0013);
    check("rst_pc", PC_FD, 32'd0);
    post();

    // Start-up stream and a three-cycle wait state at 0x10
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      reg_FD_stall = vecs[i].stall;
      pre(vecs[i].ack);
      check($sformatf("v%0d_req", i), imem.imem_req, vecs[i].exp_req);
      if (vecs[i].exp_req) check($sformatf("v%0d_addr", i), imem.imem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_starved", i), fetch_starved, vecs[i].exp_starved);
      check($sformatf("v%0d_valid", i), valid_FD, vecs[i].exp_valid);
      check($sformatf("v%0d_pc", i), PC_FD, vecs[i].exp_pc);
      post();
    end

    // Stall for four cycles: buffer fills, requests stop, IF/ID holds
    reg_FD_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pre(1'b1);
      check("stall_starved", fetch_starved, 32'd0);
      check("stall_hold_pc", PC_FD, 32'h0000_0018);
      check("stall_hold_valid", valid_FD, 32'd1);
      if (i >= 2) check("stall_req_off", imem.imem_req, 32'd0);
      post();
      if (i == 1) check("stall_buf_full", dut.buf_count, 32'd2);
    end
    reg_FD_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pre(1'b1);
      post();
    end

    // Redirect while 0x20 is outstanding and unacknowledged
    rst_n = 1'b0;
    pre(1'b1);
    post();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pre(1'b1);
      post();
    end
    check("pre_branch_addr", imem.imem_addr, 32'h0000_0020);
    Branch_ID        = 1'b1;
    branch_target_ID = 32'h0000_0100;
    pre(1'b0);
    check("branch_req", imem.imem_req, 32'd1);
    post();
    Branch_ID = 1'b0;
    check("drop_state", dut.state, DROP);
    pre(1'b1);
    check("drop_req_held", imem.imem_req, 32'd1);
    check("drop_addr_held", imem.imem_addr, 32'h0000_0020);
    post();
    check("redirect_addr", imem.imem_addr, 32'h0000_0100);
    check("redirect_req", imem.imem_req, 32'd1);
    for (int i = 0; i < 3; i++) begin
      pre(1'b1);
      post();
    end

    // Flush with a redirect to 0x40 while the buffer holds two entries
    reg_FD_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pre(1'b1);
      post();
    end
    check("flush_buf_pre", dut.buf_count, 32'd2);
    reg_FD_stall     = 1'b0;
    reg_FD_flush     = 1'b1;
    Branch_ID        = 1'b1;
    branch_target_ID = 32'h0000_0040;
    pre(1'b1);
    post();
    reg_FD_flush = 1'b0;
    Branch_ID    = 1'b0;
    check("flush_valid", valid_FD, 32'd0);
    check("flush_inst", inst_FD, 32'h0000_0013);
    check("flush_buf_empty", dut.buf_count, 32'd0);
    n = 0;
    do begin
      pre(1'b1);
      post();
      n++;
    end while (!valid_FD && n < 6);
    check("after_flush_valid", valid_FD, 32'd1);
    check("after_flush_pc", PC_FD, 32'h0000_0040);

    // Reset for one cycle while 0x80 is outstanding, then a stray ack
    n = 0;
    while (imem.imem_addr !== 32'h0000_0080 && n < 40) begin
      pre(1'b1);
      post();
      n++;
    end
    check("reach_0x80", imem.imem_addr, 32'h0000_0080);
    pre(1'b0);
    check("req_0x80", imem.imem_req, 32'd1);
    post();
    rst_n = 1'b0;
    pre(1'b0);
    check("midreset_req", imem.imem_req, 32'd0);
    post();
    rst_n    = 1'b1;
    PC_EN_IF = 1'b0;
    pre(1'b1);
    check("stray_req", imem.imem_req, 32'd0);
    post();
    check("stray_valid", valid_FD, 32'd0);
    check("stray_pc", PC_FD, 32'd0);
    check("stray_inst", inst_FD, 32'h0000_0013);
    PC_EN_IF = 1'b1;
    pre(1'b1);
    check("restart_addr", imem.imem_addr, 32'h0000_0000);
    check("restart_req", imem.imem_req, 32'd1);
    post();

    // Outstanding request completes with issue disabled, then drain
    PC_EN_IF = 1'b0;
    pre(1'b1);
    post();
    pre(1'b0);
    check("disabled_req", imem.imem_req, 32'd0);
    post();
    pre(1'b0);
    post();
    check("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), is the bubble instruction.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 PC_EN_IF  in  1  hazard-unit permission to issue new fetches.
REQ-006 reg_FD_EN  in  1  IF/ID register load enable.
REQ-007 reg_FD_stall  in  1  IF/ID hold request; holds even if reg_FD_EN is high.
REQ-008 reg_FD_flush  in  1  squash IF/ID contents and the fetch buffer.
REQ-009 Branch_ID  in  1  taken branch/jump resolved in ID.
REQ-010 branch_target_ID  in  32  redirect address, valid with Branch_ID.
REQ-011 imem_req  out  1  instruction-memory request valid.
REQ-012 imem_addr  out  32  word address of the request.
REQ-013 imem_ack  in  1  memory accepts and returns data this cycle; a transfer occurs when imem_req and imem_ack are both high.
REQ-014 imem_rdata  in  32  instruction, valid with imem_ack.
REQ-015 inst_FD  out  32  IF/ID instruction.
REQ-016 PC_FD  out  32  IF/ID PC.
REQ-017 valid_FD  out  1  IF/ID holds a real instruction.
REQ-018 fetch_starved  out  1  high when reg_FD_EN is high, reg_FD_stall is low, and no instruction is available, so a bubble is inserted.

Function
REQ-019 Registered fetch PC (pc_q): advances by 4 on each accepted transfer; becomes branch_target_ID when Branch_ID is high; redirect has priority.
REQ-020 Issue FSM states:
- IDLE: no request outstanding.
- REQ: imem_req high; imem_addr equals pc_q and is stable until the transfer.
- DROP: an outstanding request has been made stale by a redirect.
REQ-021 IDLE->REQ when PC_EN_IF is high and occupancy (buffer count + bypass-bound) is below 2; imem_req is asserted combinationally in that same cycle.
REQ-022 REQ stays in REQ on back-to-back issue if REQ-021 holds at transfer, else returns to IDLE.
REQ-023 Branch_ID while in REQ without imem_ack: the request is held to completion, state goes to DROP, and the response is discarded; DROP then returns to IDLE on imem_ack.
REQ-024 Branch_ID in the same cycle as the transfer: the returned data is discarded and pc_q is loaded with the target.
REQ-025 PC_EN_IF low: no new request starts; an outstanding request still completes into the buffer.
REQ-026 Fetch buffer: 2-entry FIFO of {pc, inst}.
- Full: no issue.
- Empty with reg_FD_EN high, reg_FD_stall low, and a transfer this cycle: the data bypasses to IF/ID on the same edge, so ack in cycle t gives valid_FD in cycle t+1.
REQ-027 IF/ID priority: reg_FD_flush > hold (reg_FD_stall or !reg_FD_EN) > load head/bypass > bubble.
- Flush: loads NOP_INST, valid 0, PC unchanged, and clears the buffer.
- Bubble: loads NOP_INST, valid 0.
REQ-028 Simultaneous buffer push and pop keeps the count unchanged.
REQ-029 Push to a full buffer cannot occur; this is an assertion error.
REQ-030 Throughput is 1 instruction/cycle with zero-wait memory and no hazards.

Reset
REQ-031 When rst_n is low at posedge clk:
- pc_q=RESET_PC; FSM=IDLE; buffer empty.
- inst_FD=NOP_INST; PC_FD=0; valid_FD=0.
REQ-032 A reset asserted mid-request abandons the request; a late imem_ack afterwards is ignored.
REQ-033 During reset, imem_req=0 and fetch_starved=0.

Structure
REQ-034 A shared package holds the state enum (IDLE/REQ/DROP), NOP_INST, and the IF/ID entry struct {pc, inst}.
REQ-035 The 2-entry FIFO is a sub-module, fetch_buffer, with push, pop, flush, count, and head outputs.

Verification
REQ-036 Zero-wait memory, all enables high, reset release → imem_addr 0,4,8; valid_FD from the 2nd cycle after release, with PC_FD 0,4,8 on consecutive cycles.
REQ-037 imem_ack delayed 3 cycles on addr 0x10 → imem_addr held at 0x10 for 4 cycles; fetch_starved high 3 cycles; valid_FD 0 during the gap.
REQ-038 Branch_ID with target 0x100 while request 0x20 is outstanding unacked → FSM DROP; 0x20 data never reaches IF/ID; next imem_addr is 0x100.
REQ-039 reg_FD_stall high 4 cycles with zero-wait memory → buffer fills to 2, imem_req drops, IF/ID holds; on release, PCs continue in order with none lost or duplicated.
REQ-040 reg_FD_flush together with Branch_ID (target 0x40) while the buffer holds 2 entries → next cycle valid_FD=0, inst_FD=0x00000013, buffer empty; next valid PC_FD is 0x40.
REQ-041 rst_n low for 1 cycle mid-request at 0x80 → pc_q=RESET_PC; imem_req 0 that cycle; a subsequent stray imem_ack produces no IF/ID load.
